sram_uart_tx_interface: RTL and testbench
=========================================

// Module: sram_uart_tx_interface
// PURPOSE
//  Reads a block of 16-bit words from external SRAM and serialises them on UART_TX_O as 8N1 frames.
//  Each word is sent high byte first, then low byte.
//  This is the transmit-side counterpart of the UART receive/SRAM path: it returns processed image
//  data to the host.
//  The top level grants it the SRAM port while its state is active.
//  The top level drives the UART pin from it instead of tying the pin high.
// PARAMETERS
//  CLKS_PER_BIT   434  Clock cycles per UART bit (50 MHz / 115200 baud).
//  SRAM_LATENCY   2    Cycles from SRAM_address driven to SRAM_read_data valid.
// PORTS
//  Clock           in   1   System clock, 50 MHz. All logic is on the rising edge.
//  Reset           in   1   Synchronous, active-high reset.
//  Start           in   1   One-cycle pulse that begins a transfer. Ignored while Busy.
//  Base_address    in   18  First SRAM word address. Sampled on Start.
//  Word_count      in   18  Number of words to send. Sampled on Start.
//  Busy            out  1   High from the cycle after Start until Done.
//  Done            out  1   One-cycle pulse after the last stop bit.
//  SRAM_address    out  18  Registered read address.
//  SRAM_read_data  in   16  Read data from the SRAM controller.
//  SRAM_we_n       out  1   Tied to 1. The block never writes.
//  UART_TX_O       out  1   Serial line. Idles high.
// BEHAVIOUR
//  Reset: all outputs take their reset values at the next edge, including mid-frame. No partial frame
//   resumes after reset.
//   UART_TX_O=1, Busy=0, Done=0, SRAM_address=0, SRAM_we_n=1, state=S_TX_IDLE.
//  States: S_TX_IDLE, S_TX_READ, S_TX_START, S_TX_DATA, [S_TX_PARITY], S_TX_STOP, S_TX_DONE.
//  S_TX_IDLE
//   - Start=1 and Word_count!=0: latch the inputs, SRAM_address<=Base_address, go to S_TX_READ.
//   - Start=1 and Word_count==0: go straight to S_TX_DONE. Nothing is transmitted.
//  S_TX_READ
//   - Holds SRAM_address for SRAM_LATENCY cycles.
//   - Then captures SRAM_read_data into a 16-bit shift register, byte_sel<=0 (high byte), and goes
//     to S_TX_START.
//  Bit period: every line state lasts exactly CLKS_PER_BIT cycles, timed by a baud counter running
//   0..CLKS_PER_BIT-1. The counter is cleared on every state entry.
//  S_TX_START: UART_TX_O=0.
//  S_TX_DATA: 8 bits, LSB first, from the selected byte. A 3-bit counter tracks the bit index.
//  S_TX_STOP: UART_TX_O=1. At the end of the stop bit:
//   - byte_sel==0: byte_sel<=1, go to S_TX_START. Back-to-back, no idle gap.
//   - byte_sel==1 and words remain: SRAM_address<=SRAM_address+1, go to S_TX_READ.
//     The line stays high during the read.
//   - byte_sel==1 and last word: go to S_TX_DONE.
//  S_TX_DONE: Done=1 for one cycle, Busy<=0, then S_TX_IDLE.
//  Remaining-word counter: 18 bits, decremented per word; the last word is remaining==1.
//  SRAM_address wrap: increments modulo 2^18; the caller keeps the range in bounds.
//  Start while Busy: ignored. Start in the same cycle as Done: ignored, because the state is not
//   S_TX_IDLE.
//  Timing:
//   - Start to the start-bit falling edge: SRAM_LATENCY+2 cycles.
//   - One word: 2*10*CLKS_PER_BIT cycles of line time, plus SRAM_LATENCY+1 cycles of read gap.
// CONFIGURATION
//  UART_TX_PARITY_EN defined:
//   - S_TX_PARITY is inserted between S_TX_DATA and S_TX_STOP.
//   - It sends the even-parity bit (XOR of the 8 data bits) for one bit period.
//   - Frame is 11 bits (8E1).
//  UART_TX_PARITY_EN undefined:
//   - S_TX_PARITY and the parity logic are absent.
//   - Frame is 10 bits (8N1).
// STRUCTURE
//  Shared package uart_tx_pkg:
//   - tx_state_type enum, including S_TX_PARITY (unused when parity is off).
//   - UART_IDLE_LEVEL=1'b1, UART_START_LEVEL=1'b0, UART_DATA_BITS=4'd8.
//  Sub-module uart_tx_byte_serializer owns the baud counter, bit counter and line driver.
//   - Interface: Load / Byte_in[7:0] / Ready / TX.
//   - The parent owns the SRAM sequencing and the word and byte selection.
// TESTING (CLKS_PER_BIT=4, SRAM_LATENCY=2 for speed)
//  1. Base=0x00010, Count=1, mem[0x10]=0xA55A -> frames 0xA5 then 0x5A; bits LSB first;
//     start bit goes low at Start+4; Done pulses once, 80 cycles after the first start edge.
//  2. Count=3 at 0x3FFFE, mem=0x1234,0x5678,0x9ABC -> bytes 12 34 56 78 9A BC in order;
//     addresses 0x3FFFE, 0x3FFFF, 0x00000 (wrap).
//  3. Count=0 -> Done at Start+1; UART_TX_O stays high; SRAM_address unchanged.
//  4. Pulse Reset during the 3rd data bit -> next cycle UART_TX_O=1, Busy=0, state S_TX_IDLE;
//     a new Start then sends a correct first frame.
//  5. Start pulsed again mid-transfer -> ignored; byte count and Done timing are identical to
//     scenario 2.
//  6. With UART_TX_PARITY_EN, word 0x0701 -> 0x07 parity 1, 0x01 parity 1; 11-bit frames.
//     Without it, no parity bit is sent and stop follows bit 7.
//  Checker: a bench UART decoder samples mid-bit. SRAM_we_n must be 1 on every cycle.

Source files
------------

// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_pkg
//  Purpose  : Shared state encoding and line constants for the SRAM-to-UART
//             transmit path.
//  Revision : 1.0  initial release
// ============================================================================
package uart_tx_pkg;

    typedef enum logic [2:0] {
        S_TX_IDLE   = 3'd0,
        S_TX_READ   = 3'd1,
        S_TX_START  = 3'd2,
        S_TX_DATA   = 3'd3,
        S_TX_PARITY = 3'd4,
        S_TX_STOP   = 3'd5,
        S_TX_DONE   = 3'd6
    } tx_state_type;

    localparam logic       UART_IDLE_LEVEL  = 1'b1;
    localparam logic       UART_START_LEVEL = 1'b0;
    localparam logic [3:0] UART_DATA_BITS   = 4'd8;

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_byte_serializer
//  Purpose  : Sends one byte as a UART frame (start, 8 data LSB first,
//             optional even parity when UART_TX_PARITY_EN is defined, stop).
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_byte_serializer
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLOCK_50_I,
    input  logic       Reset,
    input  logic       Load,
    input  logic [7:0] Byte_in,
    output logic       Ready,
    output logic       TX
);

    localparam int               BAUD_W      = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       C_LAST_BIT  = 3'(UART_DATA_BITS - 4'd1);

    tx_state_type      r_phase;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic              r_tx;
`ifdef UART_TX_PARITY_EN
    logic              r_parity;
`endif

    logic w_bit_end;

    assign w_bit_end = (r_baud == C_BAUD_LAST);
    // Accepting a load in the last stop cycle lets frames run back to back.
    assign Ready     = (r_phase == S_TX_IDLE) || ((r_phase == S_TX_STOP) && w_bit_end);
    assign TX        = r_tx;

    always_ff @(posedge CLOCK_50_I) begin
        if (Reset) begin
            r_phase  <= S_TX_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_tx     <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else if (Load && Ready) begin
            r_phase  <= S_TX_START;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= Byte_in;
            r_tx     <= UART_START_LEVEL;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^Byte_in;
`endif
        end else begin
            r_baud <= w_bit_end ? '0 : r_baud + BAUD_W'(1);
            case (r_phase)
                S_TX_START: begin
                    if (w_bit_end) begin
                        r_phase <= S_TX_DATA;
                        r_tx    <= r_shift[0];
                    end
                end
                S_TX_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit == C_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            r_phase <= S_TX_PARITY;
                            r_tx    <= r_parity;
`else
                            r_phase <= S_TX_STOP;
                            r_tx    <= UART_IDLE_LEVEL;
`endif
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_TX_PARITY: begin
                    if (w_bit_end) begin
                        r_phase <= S_TX_STOP;
                        r_tx    <= UART_IDLE_LEVEL;
                    end
                end
`endif
                S_TX_STOP: begin
                    if (w_bit_end) begin
                        r_phase <= S_TX_IDLE;
                        r_tx    <= UART_IDLE_LEVEL;
                    end
                end
                default: begin
                    r_phase <= S_TX_IDLE;
                    r_baud  <= '0;
                    r_tx    <= UART_IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_uart_tx_interface.sv
`default_nettype none
// ============================================================================
//  Module   : sram_uart_tx_interface
//  Purpose  : Reads a block of 16-bit SRAM words and sends each one high byte
//             first as UART frames. UART_TX_PARITY_EN adds an even-parity bit.
//  Revision : 1.0  initial release
// ============================================================================
module sram_uart_tx_interface
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int SRAM_LATENCY = 2
) (
    input  logic        CLOCK_50_I,
    input  logic        Reset,
    input  logic        Start,
    input  logic [17:0] Base_address,
    input  logic [17:0] Word_count,
    output logic        Busy,
    output logic        Done,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic        SRAM_we_n,
    output logic        UART_TX_O
);

    localparam int              LAT_W      = $clog2(SRAM_LATENCY + 2);
    localparam logic [LAT_W-1:0] C_LAT_LAST = LAT_W'(SRAM_LATENCY);

    tx_state_type     r_state;
    logic [LAT_W-1:0] r_lat;
    logic [17:0]      r_remaining;
    logic [7:0]       r_low_byte;
    logic             r_byte_sel;

    logic       w_read_done;
    logic       w_ser_ready;
    logic       w_load;
    logic [7:0] w_byte_in;

    assign SRAM_we_n = 1'b1;

    // The high byte goes straight from the SRAM bus so the start bit can
    // begin on the same edge the word is captured.
    assign w_read_done = (r_state == S_TX_READ) && (r_lat == C_LAT_LAST);
    assign w_load      = w_read_done || ((r_state == S_TX_DATA) && w_ser_ready && !r_byte_sel);
    assign w_byte_in   = w_read_done ? SRAM_read_data[15:8] : r_low_byte;

    uart_tx_byte_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_serializer (
        .CLOCK_50_I(CLOCK_50_I),
        .Reset     (Reset),
        .Load      (w_load),
        .Byte_in   (w_byte_in),
        .Ready     (w_ser_ready),
        .TX        (UART_TX_O)
    );

    // S_TX_DATA covers the whole frame in flight; the serializer walks the
    // start/data/parity/stop bits and raises Ready in the last stop cycle.
    always_ff @(posedge CLOCK_50_I) begin
        if (Reset) begin
            r_state      <= S_TX_IDLE;
            r_lat        <= '0;
            r_remaining  <= '0;
            r_low_byte   <= '0;
            r_byte_sel   <= 1'b0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            SRAM_address <= '0;
        end else begin
            Done <= 1'b0;
            case (r_state)
                S_TX_IDLE: begin
                    if (Start) begin
                        Busy <= 1'b1;
                        if (Word_count != 18'd0) begin
                            SRAM_address <= Base_address;
                            r_remaining  <= Word_count;
                            r_lat        <= '0;
                            r_state      <= S_TX_READ;
                        end else begin
                            Done    <= 1'b1;
                            r_state <= S_TX_DONE;
                        end
                    end
                end
                S_TX_READ: begin
                    if (w_read_done) begin
                        r_low_byte <= SRAM_read_data[7:0];
                        r_byte_sel <= 1'b0;
                        r_state    <= S_TX_DATA;
                    end else begin
                        r_lat <= r_lat + LAT_W'(1);
                    end
                end
                S_TX_DATA: begin
                    if (w_ser_ready) begin
                        if (!r_byte_sel) begin
                            r_byte_sel <= 1'b1;
                        end else if (r_remaining != 18'd1) begin
                            r_remaining  <= r_remaining - 18'd1;
                            SRAM_address <= SRAM_address + 18'd1;
                            r_lat        <= '0;
                            r_state      <= S_TX_READ;
                        end else begin
                            r_remaining <= '0;
                            Done        <= 1'b1;
                            r_state     <= S_TX_DONE;
                        end
                    end
                end
                S_TX_DONE: begin
                    Busy    <= 1'b0;
                    r_state <= S_TX_IDLE;
                end
                default: begin
                    r_state <= S_TX_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_uart_tx_interface.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_uart_tx_interface
//  Purpose  : Directed self-checking bench: SRAM model, mid-bit UART decoder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_uart_tx_interface;

    localparam int CPB = 4;
    localparam int LAT = 2;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11 * CPB;
`else
    localparam int FRAME = 10 * CPB;
`endif
    localparam int GAP = LAT + 1;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [17:0] Base_address = '0;
    logic [17:0] Word_count = '0;
    logic        Busy, Done, SRAM_we_n, UART_TX_O;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_read_data = '0;

    sram_uart_tx_interface #(.CLKS_PER_BIT(CPB), .SRAM_LATENCY(LAT)) dut (
        .CLOCK_50_I    (clk),
        .Reset         (Reset),
        .Start         (Start),
        .Base_address  (Base_address),
        .Word_count    (Word_count),
        .Busy          (Busy),
        .Done          (Done),
        .SRAM_address  (SRAM_address),
        .SRAM_read_data(SRAM_read_data),
        .SRAM_we_n     (SRAM_we_n),
        .UART_TX_O     (UART_TX_O)
    );

    always #5 clk = ~clk;

    // Two-stage read pipeline: data valid LAT cycles after the address.
    logic [15:0] mem [logic [17:0]];
    logic [15:0] rd_p1 = '0;
    always @(posedge clk) begin
        rd_p1          <= mem.exists(SRAM_address) ? mem[SRAM_address] : 16'h0000;
        SRAM_read_data <= rd_p1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int done_cnt = 0;
    int done_cyc = -1;
    int we_bad   = 0;
    always @(negedge clk) begin
        if (Done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (cyc > 0 && SRAM_we_n !== 1'b1) we_bad = we_bad + 1;
    end

    typedef struct {
        logic [7:0]  data;
        logic        par;
        logic        start_ok;
        logic        stop_ok;
        int          cyc;
        logic [17:0] addr;
    } frame_t;
    frame_t rx_q[$];

    initial begin : decoder
        frame_t f;
        forever begin
            @(negedge clk);
            if (UART_TX_O === 1'b0 && Reset === 1'b0) begin
                f.cyc  = cyc;
                f.addr = SRAM_address;
                repeat (CPB / 2) @(negedge clk);
                f.start_ok = (UART_TX_O === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    f.data[i] = UART_TX_O;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                f.par = UART_TX_O;
`else
                f.par = 1'b0;
`endif
                repeat (CPB) @(negedge clk);
                f.stop_ok = (UART_TX_O === 1'b1);
                rx_q.push_back(f);
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic pulse_start(input logic [17:0] base, input logic [17:0] cnt, output int st);
        @(negedge clk);
        Start = 1'b1; Base_address = base; Word_count = cnt; st = cyc;
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (done_cnt > d0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++; if (UART_TX_O !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", UART_TX_O); end
        total++; if (Busy !== 1'b0 || Done !== 1'b0) begin bad++; $display("FAIL reset_busy_done: got %b%b want 00", Busy, Done); end
        total++; if (SRAM_address !== 18'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", SRAM_address); end
        total++; if (SRAM_we_n !== 1'b1) begin bad++; $display("FAIL reset_we_n: got %b want 1", SRAM_we_n); end
        Reset = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (UART_TX_O !== 1'b1 || Busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset: tx=%b busy=%b want 1/0", UART_TX_O, Busy); end
    endtask

    task automatic test_single_word;
        int st, q0, d0; bit ok;
        logic [7:0] exp_b [2] = '{8'hA5, 8'h5A};
        q0 = rx_q.size(); d0 = done_cnt;
        pulse_start(18'h00010, 18'd1, st);
        total++; if (Busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", Busy); end
        wait_done(d0, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_done_timeout: got none want Done"); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL single_done_count: got %0d want 1", done_cnt - d0); end
        total++; if (done_cyc - st !== 4 + 2 * FRAME) begin bad++; $display("FAIL single_done_time: got %0d want %0d", done_cyc - st, 4 + 2 * FRAME); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", Busy); end
        total++; if (rx_q.size() - q0 !== 2) begin bad++; $display("FAIL single_frames: got %0d want 2", rx_q.size() - q0); end
        for (int i = 0; i < 2; i++) begin
            if (q0 + i < rx_q.size()) begin
                total++;
                if (rx_q[q0+i].data !== exp_b[i] || !rx_q[q0+i].start_ok || !rx_q[q0+i].stop_ok ||
                    rx_q[q0+i].cyc - st !== 4 + i * FRAME) begin
                    bad++;
                    $display("FAIL single_frame%0d: got %h at +%0d want %h at +%0d", i, rx_q[q0+i].data,
                             rx_q[q0+i].cyc - st, exp_b[i], 4 + i * FRAME);
                end
            end
        end
    endtask

    task automatic test_wrap_multi(input bit poke_start);
        int st, q0, d0; bit ok;
        logic [7:0]  exp_b [6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        logic [17:0] exp_a [6] = '{18'h3FFFE, 18'h3FFFE, 18'h3FFFF, 18'h3FFFF, 18'h00000, 18'h00000};
        int exp_done;
        exp_done = 4 + 6 * FRAME + 2 * GAP;
        q0 = rx_q.size(); d0 = done_cnt;
        pulse_start(18'h3FFFE, 18'd3, st);
        if (poke_start) begin
            repeat (50) @(negedge clk);
            Start = 1'b1; Base_address = 18'h00010; Word_count = 18'd1;
            @(negedge clk);
            Start = 1'b0;
        end
        wait_done(d0, ok);
        total++; if (!ok) begin bad++; $display("FAIL multi%0d_done_timeout: got none want Done", poke_start); end
        total++; if (done_cyc - st !== exp_done || done_cnt - d0 !== 1) begin
            bad++; $display("FAIL multi%0d_done: got +%0d x%0d want +%0d x1", poke_start, done_cyc - st, done_cnt - d0, exp_done); end
        total++; if (rx_q.size() - q0 !== 6) begin bad++; $display("FAIL multi%0d_frames: got %0d want 6", poke_start, rx_q.size() - q0); end
        for (int i = 0; i < 6; i++) begin
            if (q0 + i < rx_q.size()) begin
                total++;
                if (rx_q[q0+i].data !== exp_b[i] || rx_q[q0+i].addr !== exp_a[i] || !rx_q[q0+i].stop_ok) begin
                    bad++;
                    $display("FAIL multi%0d_frame%0d: got %h@%h want %h@%h", poke_start, i, rx_q[q0+i].data,
                             rx_q[q0+i].addr, exp_b[i], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_zero_count;
        int st, q0, d0, lows; logic [17:0] a0;
        q0 = rx_q.size(); d0 = done_cnt; a0 = SRAM_address; lows = 0;
        pulse_start(18'h00123, 18'd0, st);
        // Start asserted during the Done cycle must be ignored.
        Start = 1'b1; Base_address = 18'h00010; Word_count = 18'd1;
        @(negedge clk);
        Start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (UART_TX_O !== 1'b1) lows++;
            @(negedge clk);
        end
        total++; if (done_cyc - st !== 1 || done_cnt - d0 !== 1) begin
            bad++; $display("FAIL zero_done: got +%0d x%0d want +1 x1", done_cyc - st, done_cnt - d0); end
        total++; if (lows !== 0) begin bad++; $display("FAIL zero_line: got %0d low cycles want 0", lows); end
        total++; if (SRAM_address !== a0) begin bad++; $display("FAIL zero_addr: got %h want %h", SRAM_address, a0); end
        total++; if (rx_q.size() !== q0 || Busy !== 1'b0) begin
            bad++; $display("FAIL zero_idle: got frames=%0d busy=%b want 0/0", rx_q.size() - q0, Busy); end
    endtask

    task automatic test_reset_mid_frame;
        int st, q1, d0; bit ok;
        d0 = done_cnt;
        pulse_start(18'h00020, 18'd1, st);
        repeat (16) @(negedge clk);
        total++; if (UART_TX_O !== 1'b0) begin bad++; $display("FAIL rst_bit2: got %b want 0", UART_TX_O); end
        Reset = 1'b1;
        @(negedge clk);
        total++; if (UART_TX_O !== 1'b1 || Busy !== 1'b0 || SRAM_address !== 18'h0) begin
            bad++; $display("FAIL rst_mid: got tx=%b busy=%b addr=%h want 1/0/0", UART_TX_O, Busy, SRAM_address); end
        Reset = 1'b0;
        repeat (50) @(negedge clk);
        total++; if (done_cnt !== d0) begin bad++; $display("FAIL rst_no_done: got %0d want %0d", done_cnt, d0); end
        q1 = rx_q.size(); d0 = done_cnt;
        pulse_start(18'h00010, 18'd1, st);
        wait_done(d0, ok);
        total++; if (!ok || rx_q.size() - q1 !== 2) begin
            bad++; $display("FAIL rst_restart: got done=%b frames=%0d want 1/2", ok, rx_q.size() - q1); end
        else begin
            total++; if (rx_q[q1].data !== 8'hA5 || rx_q[q1+1].data !== 8'h5A || !rx_q[q1].start_ok) begin
                bad++; $display("FAIL rst_restart_data: got %h %h want a5 5a", rx_q[q1].data, rx_q[q1+1].data); end
        end
    endtask

    task automatic test_parity_word;
        int st, q0, d0; bit ok;
        q0 = rx_q.size(); d0 = done_cnt;
        pulse_start(18'h00100, 18'd1, st);
        wait_done(d0, ok);
        total++; if (!ok || rx_q.size() - q0 !== 2) begin
            bad++; $display("FAIL parity_frames: got done=%b frames=%0d want 1/2", ok, rx_q.size() - q0); end
        else begin
            total++; if (rx_q[q0].data !== 8'h07 || rx_q[q0+1].data !== 8'h01) begin
                bad++; $display("FAIL parity_data: got %h %h want 07 01", rx_q[q0].data, rx_q[q0+1].data); end
            total++; if (!rx_q[q0].stop_ok || !rx_q[q0+1].stop_ok || rx_q[q0+1].cyc - rx_q[q0].cyc !== FRAME) begin
                bad++; $display("FAIL parity_frame_len: got %0d want %0d", rx_q[q0+1].cyc - rx_q[q0].cyc, FRAME); end
`ifdef UART_TX_PARITY_EN
            total++; if (rx_q[q0].par !== 1'b1 || rx_q[q0+1].par !== 1'b1) begin
                bad++; $display("FAIL parity_bits: got %b %b want 1 1", rx_q[q0].par, rx_q[q0+1].par); end
`endif
        end
    endtask

    task automatic test_we_n;
        total++; if (we_bad !== 0) begin bad++; $display("FAIL we_n_always_high: got %0d bad cycles want 0", we_bad); end
    endtask

    initial begin
        mem[18'h00010] = 16'hA55A;
        mem[18'h00020] = 16'h5A3C;
        mem[18'h00100] = 16'h0701;
        mem[18'h3FFFE] = 16'h1234;
        mem[18'h3FFFF] = 16'h5678;
        mem[18'h00000] = 16'h9ABC;
        test_reset;
        test_single_word;
        test_wrap_multi(1'b0);
        test_zero_count;
        test_reset_mid_frame;
        test_wrap_multi(1'b1);
        test_parity_word;
        test_we_n;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
